pipelined_adder: RTL
====================

Name: pipelined_adder

Overview:
Parametrised, pipelined successor to the team's single-cycle adder. The carry chain is split into STAGES equal chunks with a register between chunks, so wide adds close timing. A per-transaction signed/unsigned mode and an optional saturating mode are added, with valid/ready handshakes on both sides. Used as the arithmetic datapath element behind the adder test interface and in wider DUTs.

Parameters:
BIT_WIDTH, 8, operand/sum width; must be an integer multiple of STAGES
STAGES, 2, pipeline depth = number of carry-chain chunks (1..BIT_WIDTH); CHUNK = BIT_WIDTH/STAGES
SATURATE, 0, 1 = clamp on overflow, 0 = wrap

Ports:
clk  in  1  clock, rising edge
rst  in  1  reset; one clock; reset is asynchronous and active-high
in_valid  in  1  operand transaction valid
in_ready  out  1  block can accept a transaction this cycle
a  in  BIT_WIDTH  operand A
b  in  BIT_WIDTH  operand B
carry_in  in  1  carry into bit 0
signed_mode  in  1  1 = two's-complement overflow/saturation rules, 0 = unsigned
out_valid  out  1  result valid
out_ready  in  1  consumer accepts result
sum  out  BIT_WIDTH  result (wrapped or saturated)
overflow  out  1  result overflowed the BIT_WIDTH range (before saturation)

Behaviour:
- Reset (async assert, sync-safe deassert): all stage valid bits 0; out_valid=0, sum=0, overflow=0; in_ready=0 while rst high, 1 on first cycle after release.
- Accept: transfer when in_valid && in_ready on a rising edge; a, b, carry_in, signed_mode captured into stage 0.
- Stage k (0..STAGES-1) adds bits [k*CHUNK +: CHUNK] using the carry registered by stage k-1 (carry_in for k=0); upper operand bits and mode travel with the entry; lower sum bits already computed travel forward.
- Latency: result visible on out_valid exactly STAGES cycles after acceptance when never stalled; throughput 1 per cycle.
- Output register is the last stage; sum/overflow stable while out_valid && !out_ready.
- Stall: each stage has a valid bit; stage k advances when stage k+1 is empty or advancing (bubble collapsing). Last stage advances when out_ready or !out_valid. in_ready = !valid[0] || stage 0 advancing; purely combinational from state and out_ready, never from in_valid.
- Full pipeline with out_ready=0: in_ready=0; no entry lost or duplicated; order preserved.
- Simultaneous accept and drain when full: allowed (in_ready=1 if out_ready=1).
- Overflow unsigned: final carry out of MSB. Overflow signed: a[MSB]==b[MSB] && sum[MSB]!=a[MSB].
- SATURATE=1: unsigned overflow -> sum all ones; signed overflow -> 0111..1 if a[MSB]=0 else 1000..0. overflow still reports 1. SATURATE=0: sum = raw BIT_WIDTH-bit wrap.
- carry_in participates in overflow detection in both modes.
- STAGES=1: degenerates to one registered stage, latency 1.
- Reset mid-operation: all in-flight entries discarded, out_valid drops asynchronously; no result from a pre-reset transaction may appear afterwards.

Test Plan:
BIT_WIDTH=8, STAGES=2, SATURATE=0, unsigned: a=0xFF b=0x01 cin=0 -> 2 cycles later sum=0x00 overflow=1; a=0x0F b=0xF0 cin=1 -> sum=0x00 overflow=1; a=0x12 b=0x34 cin=0 -> sum=0x46 overflow=0.
Signed, SATURATE=0 then 1: a=0x7F b=0x01 -> wrap 0x80 ovf=1 / sat 0x7F ovf=1; a=0x80 b=0xFF -> wrap 0x7F ovf=1 / sat 0x80 ovf=1; a=0xFE b=0x03 -> 0x01 ovf=0 both.
Throughput: 4 back-to-back transactions (1+1, 2+2, 3+3, 4+4), out_ready=1 -> out_valid high cycles 2..5 after first accept, sums 0x02,0x04,0x06,0x08 in order, in_ready never low.
Backpressure: out_ready=0 for 5 cycles while in_valid=1 -> exactly 2 accepted, in_ready=0 thereafter, sum held stable; release -> remaining results drain in order, no duplicates.
Reset mid-flight: accept 2 transactions, assert rst between edges -> out_valid=0, sum=0 immediately; after release no stale result, first new transaction appears with latency 2.
Sweep STAGES in {1,4,8} with BIT_WIDTH=8 against a reference model over 1000 random transactions with random out_ready -> bit-exact sum/overflow, latency = STAGES when unstalled.

Source files
------------

// File: rtl/pipelined_adder.sv
// Pipelined BIT_WIDTH-bit adder: the carry chain is cut into STAGES chunks with a register per chunk,
// valid/ready on both sides, per-transaction signed/unsigned mode and optional saturation.
module pipelined_adder #(
    parameter int BIT_WIDTH = 8,
    parameter int STAGES    = 2,
    parameter bit SATURATE  = 1'b0
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [BIT_WIDTH-1:0] a,
    input  logic [BIT_WIDTH-1:0] b,
    input  logic                 carry_in,
    input  logic                 signed_mode,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [BIT_WIDTH-1:0] sum,
    output logic                 overflow
);
    localparam int CHUNK = BIT_WIDTH / STAGES;
    localparam int LAST  = STAGES - 1;
    localparam int MSB   = BIT_WIDTH - 1;
    localparam logic [BIT_WIDTH-1:0] SMAX = {1'b0, {(BIT_WIDTH-1){1'b1}}};
    localparam logic [BIT_WIDTH-1:0] SMIN = {1'b1, {(BIT_WIDTH-1){1'b0}}};

    logic [STAGES-1:0]    vld_q;
    logic [STAGES-1:0]    take;
    logic [STAGES-1:0]    vin;
    logic [BIT_WIDTH-1:0] a_q    [STAGES];
    logic [BIT_WIDTH-1:0] a_d    [STAGES];
    logic [BIT_WIDTH-1:0] b_q    [STAGES];
    logic [BIT_WIDTH-1:0] b_d    [STAGES];
    logic [BIT_WIDTH-1:0] psum_q [STAGES];
    logic [BIT_WIDTH-1:0] psum_d [STAGES];
    logic                 cy_q   [STAGES];
    logic                 cy_d   [STAGES];
    logic                 mode_q [STAGES];
    logic                 mode_d [STAGES];
    logic [BIT_WIDTH-1:0] sum_q, sum_d;
    logic                 ovf_q, ovf_d;

    function automatic logic [CHUNK:0] add_chunk(input logic [CHUNK-1:0] x,
                                                 input logic [CHUNK-1:0] y,
                                                 input logic             c);
        return {1'b0, x} + {1'b0, y} + {{CHUNK{1'b0}}, c};
    endfunction

    function automatic logic [BIT_WIDTH-1:0] saturate(input logic [BIT_WIDTH-1:0] raw,
                                                      input logic ovf,
                                                      input logic smode,
                                                      input logic a_msb);
        if (!SATURATE || !ovf) return raw;
        if (!smode)            return '1;
        return a_msb ? SMIN : SMAX;
    endfunction

    // A stage may load when it is empty or its content moves on this cycle (bubbles collapse).
    always_comb begin
        logic t;
        take = '0;
        t = !vld_q[LAST] || out_ready;
        take[LAST] = t;
        for (int k = LAST - 1; k >= 0; k--) begin
            t = !vld_q[k] || t;
            take[k] = t;
        end
    end

    assign in_ready = !rst && take[0];

    always_comb begin
        logic [BIT_WIDTH-1:0] sa, sb, ss, raw;
        logic                 sc, sm;
        logic [CHUNK:0]       ch;
        sa = '0; sb = '0; ss = '0; sc = 1'b0; sm = 1'b0; ch = '0; raw = '0;
        vin = '0;
        for (int k = 0; k < STAGES; k++) begin
            if (k == 0) begin
                sa = a; sb = b; ss = '0; sc = carry_in; sm = signed_mode;
                vin[k] = in_valid;
            end else begin
                sa = a_q[(k == 0) ? 0 : k - 1];
                sb = b_q[(k == 0) ? 0 : k - 1];
                ss = psum_q[(k == 0) ? 0 : k - 1];
                sc = cy_q[(k == 0) ? 0 : k - 1];
                sm = mode_q[(k == 0) ? 0 : k - 1];
                vin[k] = vld_q[(k == 0) ? 0 : k - 1];
            end
            ch = add_chunk(sa[k*CHUNK +: CHUNK], sb[k*CHUNK +: CHUNK], sc);
            ss[k*CHUNK +: CHUNK] = ch[CHUNK-1:0];
            a_d[k]    = sa;
            b_d[k]    = sb;
            psum_d[k] = ss;
            cy_d[k]   = ch[CHUNK];
            mode_d[k] = sm;
        end
        // Final chunk: judge overflow on the full raw sum, then clamp if enabled.
        raw   = psum_d[LAST];
        ovf_d = mode_d[LAST] ? ((a_d[LAST][MSB] == b_d[LAST][MSB]) && (raw[MSB] != a_d[LAST][MSB]))
                             : cy_d[LAST];
        sum_d = saturate(raw, ovf_d, mode_d[LAST], a_d[LAST][MSB]);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            vld_q <= '0;
            sum_q <= '0;
            ovf_q <= 1'b0;
        end else begin
            for (int k = 0; k < STAGES; k++) begin
                if (take[k]) vld_q[k] <= vin[k];
            end
            if (take[LAST] && vin[LAST]) begin
                sum_q <= sum_d;
                ovf_q <= ovf_d;
            end
        end
    end

    always_ff @(posedge clk) begin
        for (int k = 0; k < STAGES; k++) begin
            if (take[k]) begin
                a_q[k]    <= a_d[k];
                b_q[k]    <= b_d[k];
                psum_q[k] <= psum_d[k];
                cy_q[k]   <= cy_d[k];
                mode_q[k] <= mode_d[k];
            end
        end
    end

    assign out_valid = vld_q[LAST];
    assign sum       = sum_q;
    assign overflow  = ovf_q;

endmodule
